// File: rtl/instruction_fetch.sv
// Fetch stage: PC, imem request/response channel, prefetch FIFO with PC tags, redirect and HALT drain.
// Optional FETCH_BYPASS_EN: present a response combinationally when the FIFO is empty.
module instruction_fetch #(
  parameter int unsigned         PC_WIDTH   = 32,
  parameter int unsigned         FIFO_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [PC_WIDTH-1:0] start_pc,
  output logic                imem_req_valid,
  output logic [PC_WIDTH-1:0] imem_req_addr,
  input  logic                imem_req_ready,
  input  logic                imem_rsp_valid,
  input  logic [31:0]         imem_rsp_data,
  output logic                inst_valid,
  output logic [31:0]         inst_data,
  output logic [PC_WIDTH-1:0] inst_pc,
  input  logic                inst_ready,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                halt,
  output logic                busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [PC_WIDTH-1:0] ALIGN = {{(PC_WIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]       out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d, twr_q, twr_d, trd_q, trd_d;
  logic [31:0]         dmem_q [FIFO_DEPTH];
  logic [PC_WIDTH-1:0] pmem_q [FIFO_DEPTH];
  logic [PC_WIDTH-1:0] tmem_q [FIFO_DEPTH];

  logic        fetching, flush, req_fire, rsp_tracked, fifo_valid, byp, push, pop;
  logic [CW:0] occ;

  assign fetching    = (state_q == FETCH);
  assign flush       = fetching && (halt || redirect_valid);
  // Slots are reserved at request time, so occupancy counts in-flight reads too.
  assign occ         = {1'b0, cnt_q} + {1'b0, out_q};
  assign imem_req_valid = fetching && !redirect_valid && !halt && (occ < DEPTH_C);
  assign imem_req_addr  = pc_q;
  assign req_fire    = imem_req_valid && imem_req_ready;
  assign rsp_tracked = imem_rsp_valid && (out_q != '0);
  assign fifo_valid  = (cnt_q != '0);

`ifdef FETCH_BYPASS_EN
  assign byp = fetching && !flush && !fifo_valid && (drop_q == '0) && rsp_tracked;
`else
  assign byp = 1'b0;
`endif

  assign inst_valid = fifo_valid || byp;
  assign inst_data  = fifo_valid ? dmem_q[rd_q] : (byp ? imem_rsp_data : '0);
  assign inst_pc    = fifo_valid ? pmem_q[rd_q] : (byp ? tmem_q[trd_q] : '0);
  assign pop        = fifo_valid && inst_ready && !flush;
  assign push       = fetching && !flush && rsp_tracked && (drop_q == '0) && !(byp && inst_ready);
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    twr_d   = twr_q;
    trd_d   = trd_q;
    out_d   = out_q + CW'(req_fire) - CW'(rsp_tracked);
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    if (req_fire)    twr_d = twr_q + 1'b1;
    if (rsp_tracked) trd_d = trd_q + 1'b1;
    if (push)        wr_d  = wr_q + 1'b1;
    if (pop)         rd_d  = rd_q + 1'b1;
    if (rsp_tracked && (drop_q != '0)) drop_d = drop_q - 1'b1;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = start_pc & ALIGN;
        end
      end
      FETCH: begin
        if (halt || redirect_valid) begin
          // Everything still in flight after this cycle's response belongs to the old stream.
          cnt_d  = '0;
          wr_d   = '0;
          rd_d   = '0;
          drop_d = out_d;
          if (halt) state_d = DRAIN;
          else      pc_d    = redirect_pc & ALIGN;
        end else if (req_fire) begin
          pc_d = pc_q + PC_WIDTH'(4);
        end
      end
      DRAIN: begin
        if (out_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      twr_q   <= '0;
      trd_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      twr_q   <= twr_d;
      trd_q   <= trd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) tmem_q[twr_q] <= pc_q;
    if (push) begin
      dmem_q[wr_q] <= imem_rsp_data;
      pmem_q[wr_q] <= tmem_q[trd_q];
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: vector table for streaming/redirect/halt plus corner sequences.
module tb_instruction_fetch;

  logic        clk, reset, start, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] start_pc, imem_req_addr, imem_rsp_data, inst_data, inst_pc, redirect_pc;
  logic        inst_valid, inst_ready, redirect_valid, halt, busy;

  logic       w_start, w_req_valid, w_inst_valid, w_busy;
  logic [7:0] w_start_pc, w_req_addr, w_inst_pc;
  logic [31:0] w_inst_data;

  instruction_fetch #(.PC_WIDTH(32), .FIFO_DEPTH(4), .RESET_PC(32'h10)) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt), .busy(busy)
  );

  instruction_fetch #(.PC_WIDTH(8), .FIFO_DEPTH(4), .RESET_PC(8'h00)) dut_w (
    .clk(clk), .reset(reset), .start(w_start), .start_pc(w_start_pc),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr), .imem_req_ready(1'b1),
    .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
    .inst_valid(w_inst_valid), .inst_data(w_inst_data), .inst_pc(w_inst_pc), .inst_ready(1'b1),
    .redirect_valid(1'b0), .redirect_pc(8'h00), .halt(1'b0), .busy(w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct {
    logic start; logic [31:0] spc; logic rdir; logic [31:0] rpc; logic halt;
    logic rv; logic [31:0] addr; logic iv; logic [31:0] ipc; logic busy;
  } vec_t;

  mreq_t       mq[$];
  logic [31:0] dq_pc[$], dq_data[$];
  int          cyc, lat, total, bad, acc;
  logic        s_rv, s_iv, s_busy, s_fire, sw_rv;
  logic [31:0] s_addr, s_ipc, s_idata;
  logic [7:0]  sw_addr;
  vec_t        tbl[13];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA500_0000 + a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (cycle %0d): got %h want %h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: present memory response, sample outputs mid-cycle, record handshakes.
  task automatic tick();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
      mq.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    #2;
    s_rv = imem_req_valid; s_addr = imem_req_addr; s_iv = inst_valid;
    s_ipc = inst_pc; s_idata = inst_data; s_busy = busy;
    sw_rv = w_req_valid; sw_addr = w_req_addr;
    s_fire = imem_req_valid && imem_req_ready;
    if (s_fire) mq.push_back('{addr: imem_req_addr, due: cyc + lat});
    if (inst_valid && inst_ready) begin
      dq_pc.push_back(inst_pc);
      dq_data.push_back(inst_data);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0; redirect_valid = 1'b0; halt = 1'b0; inst_ready = 1'b1; w_start = 1'b0;
    imem_rsp_valid = 1'b0;
    mq.delete();
    dq_pc.delete();
    dq_data.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0; bad = 0; cyc = 0; lat = 1;
    start_pc = '0; redirect_pc = '0; w_start_pc = '0; imem_req_ready = 1'b1;
    imem_rsp_data = '0;
    do_reset();

    #2;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h10);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Streaming, ignored start, redirect, halt drain with 1-cycle memory.
    tbl[0]  = '{1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 32'h10,  1'b0, 32'h0,   1'b0};
    tbl[1]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   1'b1};
    tbl[2]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h104, 1'b0, 32'h0,   1'b1};
    tbl[3]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h108, 1'b1, 32'h100, 1'b1};
    tbl[4]  = '{1'b1, 32'h40,  1'b0, 32'h0,   1'b0, 1'b1, 32'h10C, 1'b1, 32'h104, 1'b1};
    tbl[5]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h110, 1'b1, 32'h108, 1'b1};
    tbl[6]  = '{1'b0, 32'h0,   1'b1, 32'h203, 1'b0, 1'b0, 32'h114, 1'b1, 32'h10C, 1'b1};
    tbl[7]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h200, 1'b0, 32'h0,   1'b1};
    tbl[8]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h204, 1'b0, 32'h0,   1'b1};
    tbl[9]  = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h208, 1'b1, 32'h200, 1'b1};
    tbl[10] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b0, 32'h20C, 1'b1, 32'h204, 1'b1};
    tbl[11] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h20C, 1'b0, 32'h0,   1'b1};
    tbl[12] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h20C, 1'b0, 32'h0,   1'b0};

    do_reset();
    lat = 1;
    for (int i = 0; i < 13; i++) begin
      start = tbl[i].start; start_pc = tbl[i].spc;
      redirect_valid = tbl[i].rdir; redirect_pc = tbl[i].rpc; halt = tbl[i].halt;
      tick();
      chk($sformatf("vec%0d_req_valid", i), 32'(s_rv), 32'(tbl[i].rv));
      chk($sformatf("vec%0d_req_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("vec%0d_inst_valid", i), 32'(s_iv), 32'(tbl[i].iv));
      chk($sformatf("vec%0d_busy", i), 32'(s_busy), 32'(tbl[i].busy));
      if (tbl[i].iv) begin
        chk($sformatf("vec%0d_inst_pc", i), s_ipc, tbl[i].ipc);
        chk($sformatf("vec%0d_inst_data", i), s_idata, mem_word(tbl[i].ipc));
      end
    end
    start = 1'b0; redirect_valid = 1'b0; halt = 1'b0;

    // Back-pressure: consumer stalled, only FIFO_DEPTH reads may be accepted.
    do_reset();
    lat = 1; inst_ready = 1'b0; acc = 0;
    start = 1'b1; start_pc = 32'h100;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_fire) acc++;
    end
    chk("bp_accepted", 32'(acc), 32'd4);
    chk("bp_req_valid_low", 32'(s_rv), 32'd0);
    chk("bp_inst_valid", 32'(s_iv), 32'd1);
    inst_ready = 1'b1;
    for (int i = 0; i < 40 && dq_pc.size() < 8; i++) tick();
    chk("bp_delivered", 32'(dq_pc.size()), 32'd8);
    for (int i = 0; i < 8 && i < dq_pc.size(); i++) begin
      chk($sformatf("bp_pc%0d", i), dq_pc[i], 32'h100 + 32'(4 * i));
      chk($sformatf("bp_data%0d", i), dq_data[i], mem_word(32'h100 + 32'(4 * i)));
    end

    // Asynchronous reset in the middle of a busy fetch.
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("midrst_req_addr", imem_req_addr, 32'h10);
    chk("midrst_inst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_inst_data", inst_data, 32'd0);
    chk("midrst_inst_pc", inst_pc, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);

    // Redirect with three reads in flight on a 3-cycle memory.
    do_reset();
    lat = 3;
    start = 1'b1; start_pc = 32'h100;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    chk("rd_no_req_in_redirect", 32'(s_rv), 32'd0);
    redirect_valid = 1'b0;
    for (int i = 0; i < 30 && dq_pc.size() < 3; i++) tick();
    chk("rd_delivered", 32'(dq_pc.size()), 32'd3);
    for (int i = 0; i < 3 && i < dq_pc.size(); i++) begin
      chk($sformatf("rd_pc%0d", i), dq_pc[i], 32'h200 + 32'(4 * i));
      chk($sformatf("rd_data%0d", i), dq_data[i], mem_word(32'h200 + 32'(4 * i)));
    end

    // Halt with two reads in flight, then restart at 0x40.
    do_reset();
    lat = 3;
    start = 1'b1; start_pc = 32'h300;
    tick();
    start = 1'b0;
    tick(); tick();
    halt = 1'b1;
    tick();
    chk("halt_req_valid", 32'(s_rv), 32'd0);
    halt = 1'b0;
    tick();
    chk("halt_c4_busy", 32'(s_busy), 32'd1);
    chk("halt_c4_inst_valid", 32'(s_iv), 32'd0);
    chk("halt_c4_req_valid", 32'(s_rv), 32'd0);
    tick();
    chk("halt_c5_busy", 32'(s_busy), 32'd1);
    chk("halt_c5_req_valid", 32'(s_rv), 32'd0);
    start = 1'b1; start_pc = 32'h40;
    tick();
    chk("halt_c6_busy", 32'(s_busy), 32'd0);
    chk("halt_c6_inst_valid", 32'(s_iv), 32'd0);
    start = 1'b0;
    dq_pc.delete(); dq_data.delete();
    tick();
    chk("restart_req_valid", 32'(s_rv), 32'd1);
    chk("restart_req_addr", s_addr, 32'h40);
    for (int i = 0; i < 20 && dq_pc.size() < 1; i++) tick();
    chk("restart_delivered", 32'(dq_pc.size()), 32'd1);
    if (dq_pc.size() > 0) chk("restart_first_pc", dq_pc[0], 32'h40);

    // PC wrap on the 8-bit instance.
    do_reset();
    w_start = 1'b1; w_start_pc = 8'hF8;
    tick();
    w_start = 1'b0;
    tick();
    chk("wrap_rv1", 32'(sw_rv), 32'd1);
    chk("wrap_addr1", 32'(sw_addr), 32'hF8);
    tick();
    chk("wrap_addr2", 32'(sw_addr), 32'hFC);
    tick();
    chk("wrap_rv3", 32'(sw_rv), 32'd1);
    chk("wrap_addr3", 32'(sw_addr), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
